// File: rtl/gold_seq_gen.sv
// gold_seq_gen
//   Parallel Gold sequence generator: c(n) = x1(n+1600) ^ x2(n+1600).
//   x1 is seeded with 1, x2 with c_init. Both LFSRs advance nGenBit steps per
//   output word. The 1600-step offset is applied combinationally through jump
//   masks, so the LFSR state never has to be run forward 1600 steps.
//   Words stream out over a valid/ready handshake. The final word is masked
//   down to the bits that remain. An abort drops the request.
//
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   i_start      request pulse, taken only while idle and when i_len != 0
//   i_cinit      x2 seed, sampled with an accepted start
//   i_len        number of c(n) bits requested, sampled with an accepted start
//   i_abort      drop the current request (no o_done)
//   i_ready      downstream ready
//   o_valid      o_data holds a word
//   o_data       word k, bit i = c(k*nGenBit+i)
//   o_last       marks the final word of the request
//   o_nbits      number of valid bits in o_data
//   o_busy       request in progress
//   o_done       one-cycle pulse after the final handshake
module gold_seq_gen #(
   parameter int nGenBit = 8,
   parameter int LEN_W   = 16
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               i_start,
   input  logic [30:0]                        i_cinit,
   input  logic [LEN_W-1:0]                   i_len,
   input  logic                               i_abort,
   input  logic                               i_ready,
   output logic                               o_valid,
   output logic [nGenBit-1:0]                 o_data,
   output logic                               o_last,
   output logic [$clog2(nGenBit+1)-1:0]       o_nbits,
   output logic                               o_busy,
   output logic                               o_done
);

   localparam int NB_W = $clog2(nGenBit + 1);
   localparam int EXT  = nGenBit + 31;

   // Feedback taps below x^31 of each characteristic polynomial.
   // x1: x^31 + x^3 + 1.  x2: x^31 + x^3 + x^2 + x + 1.
   localparam logic [30:0] X1_TAPS = 31'h0000_0009;
   localparam logic [30:0] X2_TAPS = 31'h0000_000F;

   // Multiplies a by x, modulo the polynomial.
   function automatic logic [30:0] mulx(input logic [30:0] a, input logic [30:0] taps);
      return {a[29:0], 1'b0} ^ (a[30] ? taps : 31'd0);
   endfunction

   function automatic logic [30:0] mulmod(input logic [30:0] a, input logic [30:0] b,
                                          input logic [30:0] taps);
      logic [30:0] r;
      r = '0;
      for (int i = 30; i >= 0; i--) begin
         r = mulx(r, taps);
         if (b[i]) r = r ^ a;
      end
      return r;
   endfunction

   // x^1600 mod p(x). Coefficient j weights x(n+j) in the expression for
   // x(n+1600), which makes it the window mask for the offset.
   // Square-and-multiply keeps elaboration loops short.
   function automatic logic [30:0] jump_mask(input logic [30:0] taps);
      logic [30:0] r;
      logic [10:0] nc;
      nc = 11'd1600;
      r  = 31'd1;
      for (int i = 10; i >= 0; i--) begin
         r = mulmod(r, r, taps);
         if (nc[i]) r = mulx(r, taps);
      end
      return r;
   endfunction

   // For x2 this evaluates to 31'd10031374.
   localparam logic [30:0] MASK1 = jump_mask(X1_TAPS);
   localparam logic [30:0] MASK2 = jump_mask(X2_TAPS);

   // Extend the 31-bit state by nGenBit further sequence bits (bit j = x(n+j)).
   function automatic logic [EXT-1:0] ext_x1(input logic [30:0] s);
      logic [EXT-1:0] e;
      e       = '0;
      e[30:0] = s;
      for (int j = 31; j < EXT; j++) e[j] = e[j-28] ^ e[j-31];
      return e;
   endfunction

   function automatic logic [EXT-1:0] ext_x2(input logic [30:0] s);
      logic [EXT-1:0] e;
      e       = '0;
      e[30:0] = s;
      for (int j = 31; j < EXT; j++) e[j] = e[j-28] ^ e[j-29] ^ e[j-30] ^ e[j-31];
      return e;
   endfunction

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t               state, state_nxt;
   logic [30:0]          x1, x2;
   logic [LEN_W-1:0]     remaining;
   logic [EXT-1:0]       x1_ext, x2_ext;
   logic [nGenBit-1:0]   c_raw, keep;
   logic [NB_W-1:0]      nb;
   logic                 last_w, load, fin, accept;

   always_comb begin
      x1_ext = ext_x1(x1);
      x2_ext = ext_x2(x2);
   end

   // One Gold bit per lane. Each lane looks at a window shifted by i positions.
   for (genvar i = 0; i < nGenBit; i++) begin : g_lane
      assign c_raw[i] = (^(x1_ext[i +: 31] & MASK1)) ^ (^(x2_ext[i +: 31] & MASK2));
      assign keep[i]  = (nb > NB_W'(i));
   end

   always_comb begin
      last_w = (remaining <= LEN_W'(nGenBit));
      nb     = last_w ? NB_W'(remaining) : NB_W'(nGenBit);
   end

   assign accept = i_start && (i_len != '0);
   assign fin    = o_valid && i_ready && o_last;
   // Abort takes priority over a load in the same cycle.
   assign load   = (state == RUN) && !i_abort && (remaining != '0) && (!o_valid || i_ready);

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)          state_nxt = RUN;
         RUN:     if (i_abort || fin)  state_nxt = IDLE;
         default:                      state_nxt = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      o_busy = (state != IDLE);
   end

   // Datapath: LFSRs, bit counter, output word register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x1        <= '0;
         x2        <= '0;
         remaining <= '0;
         o_valid   <= 1'b0;
         o_data    <= '0;
         o_last    <= 1'b0;
         o_nbits   <= '0;
         o_done    <= 1'b0;
      end else begin
         o_done <= (state == RUN) && !i_abort && fin;
         if (state == IDLE) begin
            if (accept) begin
               x1        <= 31'h1;
               x2        <= i_cinit;
               remaining <= i_len;
            end
         end else if (i_abort) begin
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            o_data    <= '0;
            o_nbits   <= '0;
            remaining <= '0;
         end else if (load) begin
            o_valid   <= 1'b1;
            o_data    <= c_raw & keep;
            o_last    <= last_w;
            o_nbits   <= nb;
            x1        <= x1_ext[nGenBit +: 31];
            x2        <= x2_ext[nGenBit +: 31];
            remaining <= remaining - LEN_W'(nb);
         end else if (fin) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_gold_seq_gen.sv
// Bench for gold_seq_gen. Four instances run in parallel: nGenBit = 8, 1, 27 and 32.
// Each instance has its own driver. One shared monitor scoreboards all of them
// against a sequence model that runs the LFSRs bit by bit.
module tb_gold_seq_gen;

   localparam int NCFG = 4;

   function automatic int gsel(input int i);
      case (i)
         0:       return 8;
         1:       return 1;
         2:       return 27;
         default: return 32;
      endcase
   endfunction

   typedef struct {
      logic [31:0] data;
      logic        last;
      int          nbits;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n [NCFG];
   logic        start [NCFG];
   logic [30:0] cinit [NCFG];
   logic [15:0] len   [NCFG];
   logic        abort [NCFG];
   logic        ready [NCFG];
   logic        vld   [NCFG];
   logic        lst   [NCFG];
   logic        busy  [NCFG];
   logic        done  [NCFG];
   logic [31:0] odat  [NCFG];
   logic [5:0]  onb   [NCFG];

   exp_t        q [NCFG][$];
   int          pct    [NCFG];
   int          hs_cnt [NCFG];
   bit          exp_done [NCFG];
   bit          held_v [NCFG];
   logic [31:0] held_d [NCFG];
   logic        held_l [NCFG];
   logic [5:0]  held_n [NCFG];
   bit          cfg_done [NCFG];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NCFG; g++) begin : cfg
      localparam int G   = gsel(g);
      localparam int NBW = $clog2(G + 1);
      logic [G-1:0]   d;
      logic [NBW-1:0] nb;
      gold_seq_gen #(.nGenBit(G), .LEN_W(16)) dut (
         .clk     (clk),
         .rst_n   (rst_n[g]),
         .i_start (start[g]),
         .i_cinit (cinit[g]),
         .i_len   (len[g]),
         .i_abort (abort[g]),
         .i_ready (ready[g]),
         .o_valid (vld[g]),
         .o_data  (d),
         .o_last  (lst[g]),
         .o_nbits (nb),
         .o_busy  (busy[g]),
         .o_done  (done[g])
      );
      assign odat[g] = 32'(d);
      assign onb[g]  = 6'(nb);
   end

   task automatic chk(input int k, input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL G=%0d %s: got 0x%0h, expected 0x%0h", gsel(k), nm, act, exp);
      end
   endtask

   // Reference: run both LFSRs from their seeds, apply the 1600 offset, then cut
   // the c(n) stream into words.
   function automatic void push_words(input int k, input bit [30:0] ci, input int ln);
      int g = gsel(k);
      bit x1 [0:2700];
      bit x2 [0:2700];
      bit c  [0:1100];
      for (int n = 0; n < 31; n++) begin
         x1[n] = (n == 0);
         x2[n] = ci[n];
      end
      for (int n = 0; n + 31 < 1600 + ln; n++) begin
         x1[n+31] = x1[n+3] ^ x1[n];
         x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
      end
      for (int n = 0; n < ln; n++) c[n] = x1[n+1600] ^ x2[n+1600];
      for (int base = 0; base < ln; base += g) begin
         exp_t e;
         int   nbits;
         nbits   = (ln - base < g) ? ln - base : g;
         e.data  = '0;
         for (int i = 0; i < nbits; i++) e.data[i] = c[base+i];
         e.nbits = nbits;
         e.last  = (base + nbits == ln);
         q[k].push_back(e);
      end
   endfunction

   task automatic cycle(input int k);
      @(posedge clk);
      #1;
      ready[k] = ($urandom_range(99) < pct[k]);
   endtask

   task automatic wait_idle(input int k);
      int n = 0;
      while ((q[k].size() != 0 || busy[k] !== 1'b0) && n < 6000) begin
         cycle(k);
         n++;
      end
      chk(k, "drain_words_left", q[k].size(), 0);
   endtask

   task automatic req(input int k, input bit [30:0] ci, input int ln, input bit wait_end);
      int n = 0;
      while (busy[k] === 1'b1 && n < 6000) begin
         cycle(k);
         n++;
      end
      start[k] = 1'b1;
      cinit[k] = ci;
      len[k]   = 16'(ln);
      if (ln != 0) push_words(k, ci, ln);
      cycle(k);
      start[k] = 1'b0;
      if (ln != 0) begin
         chk(k, "busy_after_start", busy[k], 1);
         chk(k, "valid_t1", vld[k], 0);
         cycle(k);
         chk(k, "valid_t2", vld[k], 1);
      end else begin
         chk(k, "len0_busy", busy[k], 0);
      end
      if (wait_end) wait_idle(k);
   endtask

   task automatic run_cfg(input int k);
      int g = gsel(k);
      int base;
      int n;
      bit [30:0] cis [3];
      cis = '{31'h0, 31'h1, 31'h7FFF_FFFF};
      pct[k] = 100;
      // Reset while start is active
      rst_n[k] = 1'b0; start[k] = 1'b1; cinit[k] = 31'h5A5_A5A5; len[k] = 16'd7;
      abort[k] = 1'b0; ready[k] = 1'b1;
      repeat (2) cycle(k);
      start[k] = 1'b0;
      chk(k, "rst_valid", vld[k], 0);
      chk(k, "rst_last",  lst[k], 0);
      chk(k, "rst_done",  done[k], 0);
      chk(k, "rst_busy",  busy[k], 0);
      chk(k, "rst_data",  odat[k], 0);
      chk(k, "rst_nbits", onb[k], 0);
      rst_n[k] = 1'b1;
      // Reset in the middle of a request
      req(k, 31'h123_4567, 20 * g, 0);
      repeat (2) cycle(k);
      ready[k] = 1'b0; rst_n[k] = 1'b0;
      cycle(k);
      rst_n[k] = 1'b1;
      chk(k, "midrst_valid", vld[k], 0);
      chk(k, "midrst_busy",  busy[k], 0);
      chk(k, "midrst_last",  lst[k], 0);
      q[k].delete();
      // Golden streams: full words, partial last word, back-pressure
      req(k, 31'h091A_2B3C, 64, 1);
      req(k, 31'h1, 13, 1);
      pct[k] = 50;
      req(k, 31'($urandom), 40, 1);
      // Zero-length start is ignored
      pct[k] = 100;
      req(k, 31'h77, 0, 0);
      repeat (3) begin
         cycle(k);
         chk(k, "len0_valid", vld[k], 0);
         chk(k, "len0_busy_hold", busy[k], 0);
      end
      // Start during RUN is ignored
      pct[k] = 60;
      req(k, 31'h0AB_CDEF, 12 * g, 0);
      cycle(k);
      start[k] = 1'b1; cinit[k] = 31'h7FFF_0000; len[k] = 16'd3;
      cycle(k);
      start[k] = 1'b0;
      wait_idle(k);
      // Abort after two words, then restart at once
      pct[k] = 70;
      base = hs_cnt[k];
      req(k, 31'h246_8ACE, 10 * g, 0);
      n = 0;
      while (hs_cnt[k] < base + 2 && n < 3000) begin
         cycle(k);
         n++;
      end
      chk(k, "abort_two_words", hs_cnt[k] - base, 2);
      ready[k] = 1'b0; abort[k] = 1'b1;
      cycle(k);
      abort[k] = 1'b0;
      chk(k, "abort_valid", vld[k], 0);
      chk(k, "abort_busy",  busy[k], 0);
      chk(k, "abort_last",  lst[k], 0);
      q[k].delete();
      req(k, 31'h246_8ACE, 3 * g + 1, 1);
      // Long streams and single-bit requests over corner seeds
      pct[k] = 100;
      for (int i = 0; i < 3; i++) begin
         req(k, cis[i], 1000, 1);
         req(k, cis[i], 1, 1);
      end
      // Random requests with random back-pressure
      repeat (4) begin
         pct[k] = $urandom_range(30, 100);
         req(k, 31'($urandom), $urandom_range(1, 200), 1);
      end
      repeat (3) cycle(k);
   endtask

   // Monitor: handshakes pop the scoreboard, stalls must hold the word, and
   // o_done must pulse exactly once after each final handshake.
   always @(negedge clk) begin
      for (int k = 0; k < NCFG; k++) begin
         exp_t e;
         if (exp_done[k]) begin
            chk(k, "done_pulse", done[k], 1);
            chk(k, "valid_after_last", vld[k], 0);
            exp_done[k] = 1'b0;
         end else if (done[k] === 1'b1) begin
            chk(k, "spurious_done", done[k], 0);
         end
         if (vld[k] === 1'b1 && held_v[k]) begin
            chk(k, "stall_data",  odat[k], held_d[k]);
            chk(k, "stall_last",  lst[k],  held_l[k]);
            chk(k, "stall_nbits", onb[k],  held_n[k]);
         end
         held_v[k] = 1'b0;
         if (vld[k] === 1'b1 && ready[k] === 1'b1) begin
            hs_cnt[k]++;
            if (q[k].size() == 0) begin
               chk(k, "words_expected", q[k].size(), 1);
            end else begin
               e = q[k].pop_front();
               chk(k, "word_data",  odat[k], e.data);
               chk(k, "word_last",  lst[k],  e.last);
               chk(k, "word_nbits", onb[k],  e.nbits);
               if (e.last) exp_done[k] = 1'b1;
            end
         end else if (vld[k] === 1'b1) begin
            held_v[k] = 1'b1;
            held_d[k] = odat[k];
            held_l[k] = lst[k];
            held_n[k] = onb[k];
         end
      end
   end

   initial begin
      bit all;
      for (int k = 0; k < NCFG; k++) begin
         rst_n[k] = 1'b0; start[k] = 1'b0; cinit[k] = '0; len[k] = '0;
         abort[k] = 1'b0; ready[k] = 1'b0; pct[k] = 100; hs_cnt[k] = 0;
         exp_done[k] = 1'b0; held_v[k] = 1'b0; cfg_done[k] = 1'b0;
      end
      for (int k = 0; k < NCFG; k++) begin
         fork
            automatic int kk = k;
            begin
               run_cfg(kk);
               cfg_done[kk] = 1'b1;
            end
         join_none
      end
      all = 1'b0;
      for (int c = 0; c < 80000 && !all; c++) begin
         @(posedge clk);
         all = 1'b1;
         for (int k = 0; k < NCFG; k++) if (!cfg_done[k]) all = 1'b0;
      end
      if (!all) begin
         n_chk++;
         n_fail++;
         $display("FAIL global_timeout: drivers still running, expected all finished");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
